// File: rtl/xosera_reset_seq_if.sv
// Board reset pin/output bundle between the pin-side logic and the reset sequencer.
// Latency: none, wires only.
// Backpressure: none, level signals only.
interface xosera_reset_seq_if #(
   parameter int NUM_STAGES = 3
);
   logic                  pll_lock_i;
   logic                  nreset_btn_i;
   logic                  reboot_req_i;
   logic [NUM_STAGES-1:0] rst_o;
   logic                  ready_o;
   logic [1:0]            cause_o;

   // Sequencer side: samples pins, drives staged resets.
   modport slave (
      input  pll_lock_i,
      input  nreset_btn_i,
      input  reboot_req_i,
      output rst_o,
      output ready_o,
      output cause_o
   );

   // Board/top side: drives pins, consumes staged resets.
   modport master (
      output pll_lock_i,
      output nreset_btn_i,
      output reboot_req_i,
      input  rst_o,
      input  ready_o,
      input  cause_o
   );
endinterface

// File: rtl/xosera_reset_seq.sv
// Staged board reset sequencer: synchronizes PLL lock and button, debounces release, releases resets in order.
// Latency: 2 cycles pin sync + 1 registered cycle to rst_o; release 2^CNT_WIDTH+1 cycles after conditions settle.
// Backpressure: none; any abort source immediately reasserts every stage.
module xosera_reset_seq #(
   parameter int CNT_WIDTH      = 8,
   parameter int DEBOUNCE_WIDTH = 16,
   parameter int NUM_STAGES     = 3,
   parameter int STAGE_GAP      = 4
) (
   input  logic              clk,
   input  logic              reset,
   xosera_reset_seq_if.slave bus
);

   localparam int GAP_W  = $clog2(STAGE_GAP + 1);
   localparam int IDX_W  = $clog2(NUM_STAGES + 1);
   // Stage index counts releases made inside STAGGER; bit 0 is released on entry.
   localparam int LAST_K = (NUM_STAGES > 1) ? NUM_STAGES - 2 : 0;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_K);

   typedef enum logic [1:0] {
      S_HOLD    = 2'd0,
      S_COUNT   = 2'd1,
      S_STAGGER = 2'd2,
      S_RUN     = 2'd3
   } state_t;

   logic                      r_lock_m, r_lock_s;
   logic                      r_btn_m, r_btn_s;
   logic                      r_held;
   logic [DEBOUNCE_WIDTH-1:0] r_deb_cnt;

   state_t                    r_state,     w_state_nxt;
   logic [CNT_WIDTH-1:0]      r_hold_cnt,  w_hold_nxt;
   logic [GAP_W-1:0]          r_gap_cnt,   w_gap_nxt;
   logic [IDX_W-1:0]          r_stage_idx, w_idx_nxt;
   logic [NUM_STAGES-1:0]     r_rst,       w_rst_nxt;
   logic                      r_ready,     w_ready_nxt;
   logic [1:0]                r_cause,     w_cause_nxt;

   logic                      w_held_eff;
   logic                      w_abort;

   // A low btn_s sets held on this edge anyway, so treat it as held now; this keeps button-to-reset at 3 edges.
   assign w_held_eff = r_held | ~r_btn_s;
   assign w_abort    = ~r_lock_s | w_held_eff | bus.reboot_req_i;

   // Two-flop synchronizers; reset makes the PLL look unlocked and the button look pressed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_lock_m <= 1'b0;
         r_lock_s <= 1'b0;
         r_btn_m  <= 1'b0;
         r_btn_s  <= 1'b0;
      end else begin
         r_lock_m <= bus.pll_lock_i;
         r_lock_s <= r_lock_m;
         r_btn_m  <= bus.nreset_btn_i;
         r_btn_s  <= r_btn_m;
      end
   end

   // Button release debounce: held drops only after 2^DEBOUNCE_WIDTH consecutive high samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_held    <= 1'b1;
         r_deb_cnt <= '0;
      end else if (!r_btn_s) begin
         r_held    <= 1'b1;
         r_deb_cnt <= '0;
      end else if (r_held) begin
         if (r_deb_cnt == '1) begin
            r_held    <= 1'b0;
            r_deb_cnt <= '0;
         end else begin
            r_deb_cnt <= r_deb_cnt + DEBOUNCE_WIDTH'(1);
         end
      end
   end

   // Next-state and next-output logic for the HOLD/COUNT/STAGGER/RUN sequence.
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_gap_nxt   = r_gap_cnt;
      w_idx_nxt   = r_stage_idx;
      w_rst_nxt   = r_rst;
      w_ready_nxt = r_ready;
      w_cause_nxt = r_cause;

      if (r_state != S_HOLD && w_abort) begin
         w_state_nxt = S_HOLD;
         w_hold_nxt  = '0;
         w_gap_nxt   = '0;
         w_idx_nxt   = '0;
         w_rst_nxt   = '1;
         w_ready_nxt = 1'b0;
         if (!r_lock_s) begin
            w_cause_nxt = 2'd1;
         end else if (w_held_eff) begin
            w_cause_nxt = 2'd2;
         end else begin
            w_cause_nxt = 2'd3;
         end
      end else begin
         case (r_state)
            S_HOLD: begin
               w_hold_nxt  = '0;
               w_gap_nxt   = '0;
               w_idx_nxt   = '0;
               w_rst_nxt   = '1;
               w_ready_nxt = 1'b0;
               if (r_lock_s && !w_held_eff) begin
                  w_state_nxt = S_COUNT;
               end
            end
            S_COUNT: begin
               if (r_hold_cnt == '1) begin
                  w_hold_nxt = '0;
                  w_gap_nxt  = '0;
                  w_idx_nxt  = '0;
                  w_rst_nxt  = r_rst << 1;
                  if (NUM_STAGES == 1) begin
                     w_state_nxt = S_RUN;
                     w_ready_nxt = 1'b1;
                  end else begin
                     w_state_nxt = S_STAGGER;
                  end
               end else begin
                  w_hold_nxt = r_hold_cnt + CNT_WIDTH'(1);
               end
            end
            S_STAGGER: begin
               if (r_gap_cnt == GAP_LAST) begin
                  w_gap_nxt = '0;
                  // Stages release strictly in order, so shifting in a zero clears the next bit.
                  w_rst_nxt = r_rst << 1;
                  if (r_stage_idx == IDX_LAST) begin
                     w_idx_nxt   = '0;
                     w_state_nxt = S_RUN;
                     w_ready_nxt = 1'b1;
                  end else begin
                     w_idx_nxt = r_stage_idx + IDX_W'(1);
                  end
               end else begin
                  w_gap_nxt = r_gap_cnt + GAP_W'(1);
               end
            end
            S_RUN: begin
               w_state_nxt = S_RUN;
            end
            default: begin
               w_state_nxt = S_HOLD;
               w_rst_nxt   = '1;
               w_ready_nxt = 1'b0;
            end
         endcase
      end
   end

   // State, counters and registered outputs; reset forces everything back to power-up HOLD.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_HOLD;
         r_hold_cnt  <= '0;
         r_gap_cnt   <= '0;
         r_stage_idx <= '0;
         r_rst       <= '1;
         r_ready     <= 1'b0;
         r_cause     <= 2'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_gap_cnt   <= w_gap_nxt;
         r_stage_idx <= w_idx_nxt;
         r_rst       <= w_rst_nxt;
         r_ready     <= w_ready_nxt;
         r_cause     <= w_cause_nxt;
      end
   end

   assign bus.rst_o   = r_rst;
   assign bus.ready_o = r_ready;
   assign bus.cause_o = r_cause;

endmodule

// File: tb/tb_xosera_reset_seq.sv
// Bench for xosera_reset_seq with small counters so full sequences fit in a few hundred cycles.
// Latency: expected output changes carry the exact edge number they must appear on.
// Backpressure: none; the monitor compares every observed output change against the queue.
module tb_xosera_reset_seq;

   localparam int NS = 3;

   typedef struct {
      int         cyc;
      logic [2:0] rst;
      logic       ready;
      logic [1:0] cause;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   ev_idx = 0;
   logic mon_en = 1'b0;
   logic [5:0] mon_last;
   logic [5:0] mon_cur;
   ev_t  mon_e;
   ev_t  exp_q[$];

   always #5 clk = ~clk;

   xosera_reset_seq_if #(.NUM_STAGES(NS)) bus ();

   xosera_reset_seq #(
      .CNT_WIDTH     (4),
      .DEBOUNCE_WIDTH(3),
      .NUM_STAGES    (NS),
      .STAGE_GAP     (2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   // Edge counter: at a negedge, cyc equals the number of rising edges so far.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_ev(input int c, input logic [2:0] r, input logic rd, input logic [1:0] ca);
      ev_t e;
      e.cyc   = c;
      e.rst   = r;
      e.ready = rd;
      e.cause = ca;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Monitor: every change of the outputs must match the next queued expectation, edge number included.
   always @(negedge clk) begin
      if (mon_en) begin
         mon_cur = {bus.rst_o, bus.ready_o, bus.cause_o};
         if (mon_cur !== mon_last) begin
            mon_last = mon_cur;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_change: cyc=%0d rst=%b ready=%b cause=%0d, required no change",
                        cyc, bus.rst_o, bus.ready_o, bus.cause_o);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.cyc != cyc || mon_e.rst !== bus.rst_o ||
                   mon_e.ready !== bus.ready_o || mon_e.cause !== bus.cause_o) begin
                  n_fail++;
                  $display("FAIL event%0d: got cyc=%0d rst=%b ready=%b cause=%0d, required cyc=%0d rst=%b ready=%b cause=%0d",
                           ev_idx, cyc, bus.rst_o, bus.ready_o, bus.cause_o,
                           mon_e.cyc, mon_e.rst, mon_e.ready, mon_e.cause);
               end
            end
            ev_idx++;
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #20000;
      $display("FAIL watchdog: cyc=%0d, required finish by cycle 220", cyc);
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus; each phase queues the output changes it must cause.
   initial begin
      reset            = 1'b1;
      bus.pll_lock_i   = 1'b1;
      bus.nreset_btn_i = 1'b1;
      bus.reboot_req_i = 1'b0;

      // Power-up: reset over edges 1-2; held clears at edge 12, so T=12.
      wait_until(2);
      chk("reset_rst",   int'(bus.rst_o),   7);
      chk("reset_ready", int'(bus.ready_o), 0);
      chk("reset_cause", int'(bus.cause_o), 0);
      mon_last = 6'b111_0_00;
      mon_en   = 1'b1;
      reset    = 1'b0;
      expect_ev(29, 3'b110, 1'b0, 2'd0);

      // Lock loss while rst_o=110: stage 1 still releases at 31, abort lands at 32.
      wait_until(29);
      bus.pll_lock_i = 1'b0;
      expect_ev(31, 3'b100, 1'b0, 2'd0);
      expect_ev(32, 3'b111, 1'b0, 2'd1);

      // Lock back: lock_s high after edge 38, T=38.
      wait_until(36);
      bus.pll_lock_i = 1'b1;
      expect_ev(55, 3'b110, 1'b0, 2'd1);
      expect_ev(57, 3'b100, 1'b0, 2'd1);
      expect_ev(59, 3'b000, 1'b1, 2'd1);

      // Button bounce in RUN: pin low sampled at 63,69,75,81; abort at 65; held clears at 91.
      wait_until(62);
      bus.nreset_btn_i = 1'b0;
      expect_ev(65,  3'b111, 1'b0, 2'd2);
      expect_ev(108, 3'b110, 1'b0, 2'd2);
      expect_ev(110, 3'b100, 1'b0, 2'd2);
      expect_ev(112, 3'b000, 1'b1, 2'd2);
      wait_until(63);
      bus.nreset_btn_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_until(68 + 6 * i);
         bus.nreset_btn_i = 1'b0;
         wait_until(69 + 6 * i);
         bus.nreset_btn_i = 1'b1;
      end

      // Reboot pulse while still in HOLD (debouncing): must not change anything.
      wait_until(85);
      bus.reboot_req_i = 1'b1;
      wait_until(86);
      bus.reboot_req_i = 1'b0;

      // Reboot pulse in RUN, sampled at edge 116; T=116.
      wait_until(115);
      bus.reboot_req_i = 1'b1;
      expect_ev(116, 3'b111, 1'b0, 2'd3);
      expect_ev(133, 3'b110, 1'b0, 2'd3);
      expect_ev(135, 3'b100, 1'b0, 2'd3);
      expect_ev(137, 3'b000, 1'b1, 2'd3);
      wait_until(116);
      bus.reboot_req_i = 1'b0;

      // Lock drop reaching lock_s together with reboot at edge 143: lock loss wins.
      wait_until(140);
      bus.pll_lock_i = 1'b0;
      expect_ev(143, 3'b111, 1'b0, 2'd1);
      expect_ev(165, 3'b110, 1'b0, 2'd1);
      expect_ev(167, 3'b100, 1'b0, 2'd1);
      expect_ev(169, 3'b000, 1'b1, 2'd1);
      wait_until(142);
      bus.reboot_req_i = 1'b1;
      wait_until(143);
      bus.reboot_req_i = 1'b0;
      wait_until(146);
      bus.pll_lock_i = 1'b1;

      // Reboot to get into COUNT (T=173), then reset mid-COUNT at edge 181.
      wait_until(172);
      bus.reboot_req_i = 1'b1;
      expect_ev(173, 3'b111, 1'b0, 2'd3);
      wait_until(173);
      bus.reboot_req_i = 1'b0;
      wait_until(180);
      reset = 1'b1;
      expect_ev(181, 3'b111, 1'b0, 2'd0);
      expect_ev(208, 3'b110, 1'b0, 2'd0);
      expect_ev(210, 3'b100, 1'b0, 2'd0);
      expect_ev(212, 3'b000, 1'b1, 2'd0);
      wait_until(181);
      reset = 1'b0;

      wait_until(220);
      chk("missed_events", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
